tt_um_nefelimet_quad_decoder: RTL and testbench
===============================================

TT_UM_NEFELIMET_QUAD_DECODER -- requirements
Module: tt_um_nefelimet_quad_decoder

Interface
REQ-001 SHALL have parameter FILT_CYCLES, default 3, the number of consecutive stable clk cycles required before a synchronised input is accepted (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port ena, input, 1 bit: power-good indicator, ignored.
REQ-005 SHALL have port ui_in, input, 8 bits: [0] encoder A, [1] encoder B, [2] index Z, [3] clear (sync, active-high), [4] direction invert, [5] index-clear enable, [7:6] unused.
REQ-006 SHALL have port uo_out, output, 8 bits: position count.
REQ-007 SHALL have port uio_in, input, 8 bits: unused.
REQ-008 SHALL have port uio_out, output, 8 bits: [0] dir, [1] step pulse, [2] error sticky, [3] wrap sticky, [7:4] constant 0.
REQ-009 SHALL have port uio_oe, output, 8 bits: constant 8'h0F.

Function
REQ-010 SHALL synchronise A, B and Z through two flip-flops each before any other use.
REQ-011 SHALL run a per-input glitch filter: the filtered value takes the synchronised value only after it has differed from the filtered value for FILT_CYCLES consecutive cycles; any reversion restarts the count.
REQ-012 SHALL decode 4x quadrature from filtered {A,B}: 00->01->11->10->00 is +1, the reverse sequence is -1, no change is 0.
REQ-013 SHALL treat a simultaneous change of both filtered A and B as illegal: no count, error sticky set, stored previous state updated to the new value.
REQ-014 SHALL swap the meanings of +1 and -1 while ui_in[4]=1.
REQ-015 SHALL keep an 8-bit position with modulo-256 wrap (255+1=0, 0-1=255); each wrap sets wrap sticky.
REQ-016 SHALL pulse step high for exactly one cycle per valid count and set dir to 1 for +1 and 0 for -1; dir holds between steps.
REQ-017 SHALL deliver latency of exactly FILT_CYCLES+3 rising edges from the first edge that samples a held A/B change to the edge that updates uo_out.
REQ-018 SHALL, while clear=1, force position, error sticky and wrap sticky to 0 and suppress step.
REQ-019 SHALL, on a filtered Z rising edge while ui_in[5]=1, set position to 0 with no wrap flag and no step pulse.
REQ-020 SHALL, on coincident events in one cycle, apply priority clear > index > count.

Reset
REQ-021 SHALL, while rst_n=0, force uo_out=0, dir=0, step=0, error=0, wrap=0, all synchroniser and filter flops=0 and filter counters=0.
REQ-022 SHALL, on rst_n assertion mid-operation, discard any in-flight filter progress; the first post-reset count requires a full synchroniser+filter latency.

Configuration
REQ-023 SHALL use macro QUAD_INDEX_EN: when defined, the Z path (REQ-010, REQ-011, REQ-019) is present; when undefined, ui_in[2] and ui_in[5] are ignored, no Z synchroniser or filter exists, and position is cleared only by clear or reset.

Verification
REQ-024 SHALL cover forward steps: FILT_CYCLES=3, apply 12 forward Gray transitions each held 8 cycles -> uo_out=12, dir=1, 12 one-cycle step pulses, latency per step 6 edges.
REQ-025 SHALL cover reverse wrap: from reset, apply 1 reverse transition -> uo_out=255, dir=0, wrap=1; clear for 1 cycle -> uo_out=0, wrap=0.
REQ-026 SHALL cover glitches: a 2-cycle pulse on A -> no count, no step; the same pulse held 3 stable post-sync cycles -> one count.
REQ-027 SHALL cover illegal transitions: AB 00->11 -> error=1, uo_out unchanged; then 11->10 -> +1 counted, error stays 1.
REQ-028 SHALL cover priority: with QUAD_INDEX_EN, a Z rise coincident with a count edge and ui_in[5]=1 -> uo_out=0, no step; with clear also asserted -> uo_out=0 and error=0.
REQ-029 SHALL cover async reset mid-stream: assert rst_n=0 at position 37 between clk edges -> outputs 0 immediately; 4 transitions after release -> uo_out=4.

Source files
------------

// File: rtl/tt_um_nefelimet_quad_decoder.sv
// tt_um_nefelimet_quad_decoder: glitch-filtered 4x quadrature decoder with an 8-bit wrapping position.
// Define QUAD_INDEX_EN to add the synchronised/filtered Z index input that zeroes the position.
module tt_um_nefelimet_quad_decoder #(
  parameter int FILT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
`ifdef QUAD_INDEX_EN
  localparam int NF = 3;
`else
  localparam int NF = 2;
`endif
  localparam logic [3:0] FLAST = 4'(FILT_CYCLES - 1);
  logic [NF-1:0] s1_q, s2_q, f_q, f_d;
  logic [NF-1:0][3:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d, dlt;
  logic [7:0] pos_q, pos_d;
  logic dir_q, dir_d, step_q, step_d, err_q, err_d, wrap_q, wrap_d;
  logic clr, inv, up, dn, ill, zrise;
  logic unused;
  always_comb begin
    f_d = f_q;
    cnt_d = '0;
    for (int i = 0; i < NF; i++) begin
      if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] == FLAST) f_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end
`ifdef QUAD_INDEX_EN
  logic zp_q;
  assign zrise = f_q[2] & ~zp_q & ui_in[5];
  assign unused = &{1'b0, ena, uio_in, ui_in[7:6]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zp_q <= 1'b0;
    else zp_q <= f_q[2];
  end
`else
  assign zrise = 1'b0;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:5], ui_in[2]};
`endif
  // Gray state {A,B} mapped onto a 2-bit ring so the step is a modulo-4 difference
  assign idx_d = {f_q[0], f_q[0] ^ f_q[1]};
  assign dlt = idx_d - idx_q;
  assign ill = dlt == 2'd2;
  assign clr = ui_in[3];
  assign inv = ui_in[4];
  assign up = inv ? dlt == 2'd3 : dlt == 2'd1;
  assign dn = inv ? dlt == 2'd1 : dlt == 2'd3;
  always_comb begin
    step_d = !clr && !zrise && (up || dn);
    pos_d = (clr || zrise) ? 8'd0 : up ? pos_q + 8'd1 : dn ? pos_q - 8'd1 : pos_q;
    dir_d = step_d ? up : dir_q;
    err_d = !clr && (err_q || ill);
    wrap_d = !clr && (wrap_q || (step_d && (up ? pos_q == 8'hFF : pos_q == 8'h00)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      f_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      pos_q <= '0;
      dir_q <= 1'b0;
      step_q <= 1'b0;
      err_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      s1_q <= ui_in[NF-1:0];
      s2_q <= s1_q;
      f_q <= f_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pos_q <= pos_d;
      dir_q <= dir_d;
      step_q <= step_d;
      err_q <= err_d;
      wrap_q <= wrap_d;
    end
  end
  assign uo_out = pos_q;
  assign uio_out = {4'b0000, wrap_q, err_q, step_q, dir_q};
  assign uio_oe = 8'h0F;
endmodule

// File: tb/tb_tt_um_nefelimet_quad_decoder.sv
// tb_tt_um_nefelimet_quad_decoder: randomized segments of held encoder moves checked against a position model.
module tb_tt_um_nefelimet_quad_decoder;
  localparam int FC = 3;
`ifdef QUAD_INDEX_EN
  localparam bit IDX = 1'b1;
`else
  localparam bit IDX = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'd0, uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, errors = 0, steps = 0;
  int m_pos = 0, m_phase = 0;
  bit m_dir = 0, m_err = 0, m_wrap = 0;

  tt_um_nefelimet_quad_decoder #(.FILT_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (uio_out[1]) steps++;
  endtask

  function automatic logic [1:0] ab(int p);
    return p == 0 ? 2'b00 : p == 1 ? 2'b10 : p == 2 ? 2'b11 : 2'b01;
  endfunction

  task automatic check_state(string tag);
    check({tag, "_pos"}, uo_out, m_pos);
    check({tag, "_dir"}, uio_out[0], m_dir);
    check({tag, "_err"}, uio_out[2], m_err);
    check({tag, "_wrap"}, uio_out[3], m_wrap);
  endtask

  // d is the phase move: 1 forward, 3 backward, 0 none, 2 illegal double change
  task automatic seg(int d, bit inv, bit zr, bit clr);
    int old_pos = m_pos;
    int exp_steps = 0;
    int np;
    m_phase = (m_phase + d) & 3;
    ui_in[1:0] = ab(m_phase);
    ui_in[4] = inv;
    if (zr) begin
      ui_in[2] = 1'b1;
      ui_in[5] = 1'b1;
    end
    steps = 0;
    repeat (FC + 2) tick();
    check("latency_hold", uo_out, old_pos);
    if (clr) ui_in[3] = 1'b1;
    tick();
    ui_in[3] = 1'b0;
    if (d == 2) m_err = 1;
    if (clr) begin
      m_pos = 0;
      m_err = 0;
      m_wrap = 0;
    end else if (zr && IDX) begin
      m_pos = 0;
    end else if (d == 1 || d == 3) begin
      np = m_pos + (((d == 1) ^ inv) ? 1 : -1);
      if (np < 0 || np > 255) m_wrap = 1;
      m_dir = np > m_pos;
      m_pos = np & 255;
      exp_steps = 1;
    end
    check("decode_pos", uo_out, m_pos);
    if (zr) begin
      ui_in[2] = 1'b0;
      repeat (FC + 4) tick();
      ui_in[5] = 1'b0;
    end
    repeat (3) tick();
    check("steps", steps, exp_steps);
    check_state("seg");
  endtask

  task automatic glitch(int len, int b);
    int old_pos = m_pos;
    steps = 0;
    ui_in[b] = ~ui_in[b];
    repeat (len) tick();
    ui_in[b] = ~ui_in[b];
    repeat (FC + 5) tick();
    check("glitch_pos", uo_out, old_pos);
    check("glitch_steps", steps, 0);
  endtask

  task automatic do_clear();
    ui_in[3] = 1'b1;
    tick();
    ui_in[3] = 1'b0;
    m_pos = 0;
    m_err = 0;
    m_wrap = 0;
    check_state("clear");
  endtask

  initial begin
    int r;
    repeat (2) tick();
    check("rst_pos", uo_out, 0);
    check("rst_uio", uio_out, 0);
    check("oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    tick();
    seg(3, 0, 0, 0);
    check("rev_wrap_pos", uo_out, 255);
    do_clear();
    for (int i = 0; i < 12; i++) seg(1, 0, 0, 0);
    check("fwd12_pos", uo_out, 12);
    check("fwd12_dir", uio_out[0], 1);
    glitch(2, 0);
    seg(1, 0, 0, 0);
    seg(2, 0, 0, 0);
    check("illegal_err", uio_out[2], 1);
    seg(1, 0, 0, 0);
    check("after_illegal_err", uio_out[2], 1);
    seg(1, 0, 1, 0);
    seg(2, 0, 0, 0);
    seg(1, 0, 1, 1);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 9) glitch($urandom_range(1, FC - 1), $urandom_range(0, 1));
      seg(r < 4 || r == 9 ? 1 : r < 7 ? 3 : r == 7 ? 0 : 2,
          $urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 19) == 0);
    end
    do_clear();
    for (int i = 0; i < 37; i++) seg(1, 0, 0, 0);
    check("pre_rst_pos", uo_out, 37);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pos", uo_out, 0);
    check("async_rst_uio", uio_out, 0);
    ui_in[1:0] = 2'b00;
    m_phase = 0;
    m_pos = 0;
    m_dir = 0;
    m_err = 0;
    m_wrap = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) seg(1, 0, 0, 0);
    check("post_rst_pos", uo_out, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
